// File: rtl/mod_cnt_pkg.sv
// Shared types and helpers for the modulo-N counter bank.
// Direction encodings, per-channel operation codes and the limit helper.
package mod_cnt_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Widest channel supported by mod_limit.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_ADV,
        OP_ILLEGAL
    } ch_op_e;

    // Highest legal count for a modulus.
    function automatic logic [MAX_W-1:0] mod_limit(
        input logic [MAX_W-1:0] mod
    );
        return mod - 1'b1;
    endfunction

endpackage

// File: rtl/mod_n_channel.sv
// One modulo-N up/down counter with load, wrap pulse and error pulse.
// Ports: clk, rst, en, load, dir, load_val, mod_val -> wrap_o (comb),
//        count, tc, mod_err (registered, updated on falling edge).
module mod_n_channel
    import mod_cnt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    output logic             wrap_o,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             mod_err
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_err;

    logic [WIDTH-1:0] w_lim;
    logic             w_at_top;
    logic             w_at_zero;
    logic             w_above;
    logic             w_clamp;
    logic             w_wrap;
    ch_op_e           w_op;

    assign w_lim     = WIDTH'(mod_limit(MAX_W'(mod_val)));
    assign w_at_top  = (r_count >= w_lim);
    assign w_at_zero = (r_count == '0);
    assign w_above   = (r_count > w_lim);
    assign w_clamp   = (load_val > w_lim);

    // A zero modulus blocks both load and advance.
    always_comb begin
        w_op = OP_HOLD;
        if (mod_val == '0) begin
            if (en || load) begin
                w_op = OP_ILLEGAL;
            end
        end else if (load) begin
            w_op = OP_LOAD;
        end else if (en) begin
            w_op = OP_ADV;
        end
    end

    // Down-counter above the limit snaps without wrapping.
    assign w_wrap = (w_op == OP_ADV) &&
                    ((dir == DIR_UP) ? w_at_top : w_at_zero);

    always_ff @(negedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_tc  <= 1'b0;
            r_err <= 1'b0;
            unique case (w_op)
                OP_HOLD: begin
                end
                OP_ILLEGAL: begin
                    r_err <= 1'b1;
                end
                OP_LOAD: begin
                    r_count <= w_clamp ? w_lim : load_val;
                    r_err   <= w_clamp;
                end
                OP_ADV: begin
                    if (w_wrap) begin
                        r_count <= (dir == DIR_UP) ? '0 : w_lim;
                        r_tc    <= 1'b1;
                    end else if (dir == DIR_UP) begin
                        r_count <= r_count + 1'b1;
                    end else if (w_above) begin
                        r_count <= w_lim;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
            endcase
        end
    end

    assign wrap_o  = w_wrap;
    assign count   = r_count;
    assign tc      = r_tc;
    assign mod_err = r_err;

endmodule

// File: rtl/mod_n_counter_mc.sv
// Bank of NUM_CH modulo-N counters, optionally cascaded as one mixed-radix counter.
// Ports: clk, rst, ch_en, ch_load, dir, load_val, mod_val -> count, tc, mod_err.
module mod_n_counter_mc
    import mod_cnt_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_MOD = 256,
    parameter int CASCADE     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       ch_load,
    input  logic [NUM_CH-1:0]       dir,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic [NUM_CH*WIDTH-1:0] mod_val,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       mod_err
);

    // DEFAULT_MOD only describes what system drivers should apply.
    if (DEFAULT_MOD < 1) begin : g_bad_default_mod
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_en_i;
        logic w_wrap_i;

        // Cascaded channels step only when the lower channel wraps
        // in this same cycle.
        if (CASCADE != 0 && i > 0) begin : g_cas
            assign w_en_i = ch_en[i] & g_ch[i-1].w_wrap_i;
        end else begin : g_ind
            assign w_en_i = ch_en[i];
        end

        mod_n_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (w_en_i),
            .load    (ch_load[i]),
            .dir     (dir[i]),
            .load_val(load_val[i*WIDTH +: WIDTH]),
            .mod_val (mod_val[i*WIDTH +: WIDTH]),
            .wrap_o  (w_wrap_i),
            .count   (count[i*WIDTH +: WIDTH]),
            .tc      (tc[i]),
            .mod_err (mod_err[i])
        );
    end

endmodule

// File: tb/tb_mod_n_counter_mc.sv
// Self-checking bench for mod_n_counter_mc: independent and cascaded banks.
// Expected outputs are queued with each stimulus and checked after the edge.
module tb_mod_n_counter_mc;

    localparam int W = 8;

    logic clk;
    logic rst;

    logic [3:0]     en, ld, dr;
    logic [4*W-1:0] lv, mv;
    logic [4*W-1:0] cnt;
    logic [3:0]     tcs, errs;

    logic [1:0]     c_en, c_ld, c_dr;
    logic [2*W-1:0] c_lv, c_mv;
    logic [2*W-1:0] c_cnt;
    logic [1:0]     c_tc, c_err;

    int vectors;
    int miscompares;

    typedef struct {
        string        name;
        bit           cas;
        int           ch;
        logic [W-1:0] cnt;
        logic         tc;
        logic         err;
    } exp_t;

    exp_t sb[$];

    mod_n_counter_mc #(
        .NUM_CH(4), .WIDTH(W), .DEFAULT_MOD(256), .CASCADE(0)
    ) u_dut (
        .clk(clk), .rst(rst), .ch_en(en), .ch_load(ld), .dir(dr),
        .load_val(lv), .mod_val(mv), .count(cnt), .tc(tcs),
        .mod_err(errs)
    );

    mod_n_counter_mc #(
        .NUM_CH(2), .WIDTH(W), .DEFAULT_MOD(256), .CASCADE(1)
    ) u_cas (
        .clk(clk), .rst(rst), .ch_en(c_en), .ch_load(c_ld), .dir(c_dr),
        .load_val(c_lv), .mod_val(c_mv), .count(c_cnt), .tc(c_tc),
        .mod_err(c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string name, input bit cas, input int ch,
                        input logic [W-1:0] c, input logic t,
                        input logic e);
        exp_t x;
        x.name = name; x.cas = cas; x.ch = ch;
        x.cnt = c; x.tc = t; x.err = e;
        sb.push_back(x);
    endtask

    // Advance one active (falling) edge, then drain the scoreboard.
    task automatic tick();
        exp_t         x;
        logic [W-1:0] ac;
        logic         at, ae;
        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            if (x.cas) begin
                ac = c_cnt[x.ch*W +: W];
                at = c_tc[x.ch];
                ae = c_err[x.ch];
            end else begin
                ac = cnt[x.ch*W +: W];
                at = tcs[x.ch];
                ae = errs[x.ch];
            end
            vectors++;
            if ({ac, at, ae} !== {x.cnt, x.tc, x.err}) begin
                miscompares++;
                $display("FAIL %s ch%0d: got cnt=%0d tc=%b err=%b, want cnt=%0d tc=%b err=%b",
                         x.name, x.ch, ac, at, ae, x.cnt, x.tc, x.err);
            end
        end
    endtask

    task automatic test_reset();
        en = 4'hf; ld = '0; dr = 4'hf;
        for (int c = 0; c < 4; c++) mv[c*W +: W] = 8'd5;
        c_en = 2'b11; c_ld = '0; c_dr = 2'b11;
        c_mv = {8'd4, 8'd3};
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) push("reset", 0, c, 0, 0, 0);
            for (int c = 0; c < 2; c++) push("reset_cas", 1, c, 0, 0, 0);
            tick();
        end
        rst = 1'b0;
        en = '0;
        c_en = '0;
        tick();
    endtask

    task automatic test_up_wrap();
        logic [W-1:0] seq [5] = '{1, 2, 3, 4, 0};
        mv[0*W +: W] = 8'd5;
        dr[0] = 1'b1;
        en[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push("up_wrap", 0, 0, seq[k], seq[k] == 0, 0);
            push("up_idle_ch", 0, 3, 0, 0, 0);
            tick();
        end
        en[0] = 1'b0;
        push("up_hold", 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_down_load();
        logic [W-1:0] seq [4] = '{2, 1, 0, 9};
        mv[1*W +: W] = 8'd10;
        lv[1*W +: W] = 8'd3;
        ld[1] = 1'b1;
        push("load3", 0, 1, 3, 0, 0);
        tick();
        ld[1] = 1'b0;
        dr[1] = 1'b0;
        en[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push("down_wrap", 0, 1, seq[k], seq[k] == 9, 0);
            tick();
        end
        en[1] = 1'b0;
        lv[1*W +: W] = 8'd12;
        ld[1] = 1'b1;
        push("clamp_load", 0, 1, 9, 0, 1);
        tick();
        ld[1] = 1'b0;
        push("clamp_after", 0, 1, 9, 0, 0);
        tick();
    endtask

    task automatic test_cascade();
        c_dr = 2'b11;
        c_en = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            push("cas_ch0", 1, 0, W'(k % 3), (k % 3) == 0, 0);
            push("cas_ch1", 1, 1, W'((k / 3) % 4), k == 12, 0);
            tick();
        end
        c_en = '0;
    endtask

    task automatic test_edge();
        mv[2*W +: W] = 8'd0;
        en[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push("mod0_adv", 0, 2, 0, 0, 1);
            tick();
        end
        en[2] = 1'b0;
        ld[2] = 1'b1;
        lv[2*W +: W] = 8'd2;
        push("mod0_load", 0, 2, 0, 0, 1);
        tick();
        ld[2] = 1'b0;
        push("mod0_idle", 0, 2, 0, 0, 0);
        tick();
        mv[2*W +: W] = 8'd8;
        lv[2*W +: W] = 8'd6;
        dr[2] = 1'b1;
        ld[2] = 1'b1;
        en[2] = 1'b1;
        push("load_and_en", 0, 2, 6, 0, 0);
        tick();
        ld[2] = 1'b0;
        mv[2*W +: W] = 8'd4;
        push("shrink_up", 0, 2, 0, 1, 0);
        tick();
        push("shrink_up_next", 0, 2, 1, 0, 0);
        tick();
        en[2] = 1'b0;
        mv[3*W +: W] = 8'd1;
        dr[3] = 1'b1;
        en[3] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push("mod1", 0, 3, 0, 1, 0);
            tick();
        end
        en[3] = 1'b0;
        mv[3*W +: W] = 8'd8;
        lv[3*W +: W] = 8'd6;
        ld[3] = 1'b1;
        push("load6", 0, 3, 6, 0, 0);
        tick();
        ld[3] = 1'b0;
        mv[3*W +: W] = 8'd4;
        dr[3] = 1'b0;
        en[3] = 1'b1;
        push("shrink_down", 0, 3, 3, 0, 0);
        tick();
        push("shrink_down_next", 0, 3, 2, 0, 0);
        tick();
        en[3] = 1'b0;
    endtask

    task automatic test_mid_reset();
        mv[0*W +: W] = 8'd5;
        dr[0] = 1'b1;
        en[0] = 1'b1;
        push("pre_rst_a", 0, 0, 1, 0, 0);
        tick();
        push("pre_rst_b", 0, 0, 2, 0, 0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) push("mid_reset", 0, c, 0, 0, 0);
        tick();
        rst = 1'b0;
        push("post_rst", 0, 0, 1, 0, 0);
        tick();
        en = '0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        en = '0; ld = '0; dr = '0; lv = '0; mv = '0;
        c_en = '0; c_ld = '0; c_dr = '0; c_lv = '0; c_mv = '0;
        test_reset();
        test_up_wrap();
        test_down_load();
        test_cascade();
        test_edge();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
